// File: rtl/fetch_queue_stage_if.sv
// fetch_queue_stage_if: imem request/response and decode handoff signals; master = fetch stage, slave = memory/decode side
interface fetch_queue_stage_if #(
  parameter int N_BITS = 32
);
  logic              imem_req_vld;
  logic [N_BITS-1:0] imem_req_addr;
  logic              imem_req_rdy;
  logic              imem_resp_vld;
  logic [31:0]       imem_resp_data;
  logic              out_vld;
  logic [N_BITS-1:0] out_pc;
  logic [31:0]       out_instr;
  logic              out_rdy;
  modport master (
    output imem_req_vld, imem_req_addr, out_vld, out_pc, out_instr,
    input  imem_req_rdy, imem_resp_vld, imem_resp_data, out_rdy
  );
  modport slave (
    input  imem_req_vld, imem_req_addr, out_vld, out_pc, out_instr,
    output imem_req_rdy, imem_resp_vld, imem_resp_data, out_rdy
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC generation, in-order fetch queue and redirect flush
//   clk/rst           clock, synchronous active-high reset
//   redir_vld/tgt     prioritised redirect sources (index 0 wins)
//   f (master)        imem request/response and decode output handshakes
//   fq_count          allocated queue entries
//   resp_err          sticky flag for a response with nothing outstanding
module fetch_queue_stage #(
  parameter int N_BITS = 32,
  parameter int N_REDIR = 4,
  parameter int FQ_DEPTH = 4,
  parameter logic [N_BITS-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REDIR-1:0]        redir_vld,
  input  logic [N_REDIR*N_BITS-1:0] redir_tgt,
  fetch_queue_stage_if.master       f,
  output logic [$clog2(FQ_DEPTH):0] fq_count,
  output logic                      resp_err
);
  localparam int A = $clog2(FQ_DEPTH);
  localparam int C = A + 1;
  logic [N_BITS-1:0] pc, tgt;
  logic [N_BITS-1:0] pc_q [FQ_DEPTH];
  logic [31:0]       ins_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] filled;
  logic [A-1:0] hd, tl, fp;
  // ucnt: allocated but unfilled entries; drop: responses still owed to flushed requests
  logic [C-1:0] ucnt, drop;
  logic redir, alloc, pop, fill, err_rsp;
  always_comb begin
    tgt = '0;
    for (int i = N_REDIR - 1; i >= 0; i--)
      if (redir_vld[i]) tgt = redir_tgt[i*N_BITS +: N_BITS];
  end
  assign redir           = |redir_vld;
  assign f.imem_req_addr = pc;
  // outstanding requests (live plus flushed) never exceed the queue depth
  assign f.imem_req_vld  = !rst && !redir && (({1'b0, fq_count} + {1'b0, drop}) < (C+1)'(FQ_DEPTH));
  assign alloc           = f.imem_req_vld && f.imem_req_rdy;
  assign f.out_vld       = !rst && fq_count != '0 && filled[hd];
  assign f.out_pc        = pc_q[hd];
  assign f.out_instr     = ins_q[hd];
  assign pop             = f.out_vld && f.out_rdy && !redir;
  assign fill            = f.imem_resp_vld && !redir && drop == '0 && ucnt != '0;
  assign err_rsp         = f.imem_resp_vld && drop == '0 && ucnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      fq_count <= '0;
      ucnt     <= '0;
      drop     <= '0;
      hd       <= '0;
      tl       <= '0;
      fp       <= '0;
      filled   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (err_rsp) resp_err <= 1'b1;
      if (redir) begin
        pc       <= tgt;
        fq_count <= '0;
        ucnt     <= '0;
        hd       <= '0;
        tl       <= '0;
        fp       <= '0;
        drop     <= drop + ucnt - C'(f.imem_resp_vld && !err_rsp);
      end else begin
        if (alloc) begin
          pc         <= pc + N_BITS'(4);
          pc_q[tl]   <= pc;
          filled[tl] <= 1'b0;
          tl         <= tl + 1'b1;
        end
        if (fill) begin
          ins_q[fp]  <= f.imem_resp_data;
          filled[fp] <= 1'b1;
          fp         <= fp + 1'b1;
        end
        if (f.imem_resp_vld && drop != '0) drop <= drop - 1'b1;
        if (pop) hd <= hd + 1'b1;
        fq_count <= fq_count + C'(alloc) - C'(pop);
        ucnt     <= ucnt + C'(alloc) - C'(fill);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed checks of fetch, queueing, redirect drop and error behaviour
module tb_fetch_queue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] redir_vld = '0;
  logic [127:0] redir_tgt = '0;
  logic [2:0] fq_count;
  logic resp_err;
  int n_chk = 0, n_fail = 0;
  logic [31:0] pending[$], acc[$], pops[$];
  logic auto_rsp = 1'b0, resp_now = 1'b0, stray = 1'b0;
  fetch_queue_stage_if #(.N_BITS(32)) m();
  fetch_queue_stage dut (
    .clk(clk), .rst(rst), .redir_vld(redir_vld), .redir_tgt(redir_tgt),
    .f(m), .fq_count(fq_count), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    if (rst) pending.delete();
    m.imem_resp_vld  = 1'b0;
    m.imem_resp_data = '0;
    if (stray) m.imem_resp_vld = 1'b1;
    else if ((auto_rsp || resp_now) && pending.size() > 0) begin
      m.imem_resp_vld  = 1'b1;
      m.imem_resp_data = ~pending.pop_front();
    end
    #1;
    if (!rst && m.imem_req_vld && m.imem_req_rdy) begin
      pending.push_back(m.imem_req_addr);
      acc.push_back(m.imem_req_addr);
    end
    if (!rst && m.out_vld && m.out_rdy && redir_vld == '0) begin
      pops.push_back(m.out_pc);
      chk("instr", m.out_instr, ~m.out_pc);
    end
    @(negedge clk);
    resp_now = 1'b0;
    stray = 1'b0;
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    redir_vld = '0;
    m.imem_req_rdy = 1'b0;
    m.out_rdy = 1'b0;
    auto_rsp = 1'b0;
    cyc();
    rst = 1'b0;
    acc.delete();
    pops.delete();
  endtask
  initial begin
    m.imem_req_rdy = 1'b0;
    m.imem_resp_vld = 1'b0;
    m.imem_resp_data = '0;
    m.out_rdy = 1'b0;
    @(negedge clk);
    run(2);
    #1;
    chk("rst_out_vld", 32'(m.out_vld), 0);
    chk("rst_req_vld", 32'(m.imem_req_vld), 0);
    chk("rst_fq_count", 32'(fq_count), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_addr", m.imem_req_addr, 32'h0);
    rst = 1'b0;
    m.imem_req_rdy = 1'b1;
    m.out_rdy = 1'b1;
    auto_rsp = 1'b1;
    run(8);
    chk("seq_n_pop", 32'(pops.size() >= 3), 1);
    chk("seq_addr1", acc[1], 32'h4);
    chk("seq_addr2", acc[2], 32'h8);
    chk("seq_pc0", pops[0], 32'h0);
    chk("seq_pc1", pops[1], 32'h4);
    chk("seq_pc2", pops[2], 32'h8);
    do_reset();
    m.imem_req_rdy = 1'b1;
    auto_rsp = 1'b1;
    run(8);
    #1;
    chk("full_n_req", 32'(acc.size()), 4);
    chk("full_fq_count", 32'(fq_count), 4);
    chk("full_req_vld", 32'(m.imem_req_vld), 0);
    chk("full_out_vld", 32'(m.out_vld), 1);
    chk("full_out_pc", m.out_pc, 32'h0);
    m.out_rdy = 1'b1;
    cyc();
    m.out_rdy = 1'b0;
    #1;
    chk("full_req_after_pop", 32'(m.imem_req_vld), 1);
    chk("full_addr_after_pop", m.imem_req_addr, 32'h10);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_out_vld", 32'(m.out_vld), 0);
    chk("midrst_fq_count", 32'(fq_count), 0);
    m.out_rdy = 1'b1;
    m.imem_req_rdy = 1'b1;
    auto_rsp = 1'b0;
    acc.delete();
    pops.delete();
    run(2);
    chk("redir_unfilled", 32'(fq_count), 2);
    redir_vld = 4'b0110;
    redir_tgt = {32'h300, 32'h200, 32'h100, 32'h0};
    #1;
    chk("redir_req_vld", 32'(m.imem_req_vld), 0);
    cyc();
    redir_vld = '0;
    #1;
    chk("redir_addr", m.imem_req_addr, 32'h100);
    chk("redir_req_vld_next", 32'(m.imem_req_vld), 1);
    auto_rsp = 1'b1;
    pops.delete();
    run(10);
    chk("redir_pc0", pops[0], 32'h100);
    chk("redir_pc1", pops[1], 32'h104);
    chk("redir_resp_err", 32'(resp_err), 0);
    do_reset();
    m.imem_req_rdy = 1'b1;
    m.out_rdy = 1'b1;
    cyc();
    m.imem_req_rdy = 1'b0;
    redir_vld = 4'b0001;
    redir_tgt = {96'h0, 32'h40};
    resp_now = 1'b1;
    cyc();
    redir_vld = '0;
    m.imem_req_rdy = 1'b1;
    auto_rsp = 1'b1;
    pops.delete();
    run(8);
    chk("redir_rsp_pc0", pops[0], 32'h40);
    chk("redir_rsp_pc1", pops[1], 32'h44);
    chk("redir_rsp_err", 32'(resp_err), 0);
    do_reset();
    redir_vld = 4'b0001;
    redir_tgt = {96'h0, 32'hFFFF_FFFC};
    m.out_rdy = 1'b1;
    cyc();
    redir_vld = '0;
    m.imem_req_rdy = 1'b1;
    auto_rsp = 1'b1;
    pops.delete();
    #1;
    chk("wrap_addr0", m.imem_req_addr, 32'hFFFF_FFFC);
    cyc();
    #1;
    chk("wrap_addr1", m.imem_req_addr, 32'h0);
    run(6);
    chk("wrap_pc0", pops[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", pops[1], 32'h0);
    do_reset();
    m.out_rdy = 1'b1;
    #1;
    chk("err_init", 32'(resp_err), 0);
    stray = 1'b1;
    cyc();
    #1;
    chk("err_set", 32'(resp_err), 1);
    chk("err_fq_count", 32'(fq_count), 0);
    chk("err_out_vld", 32'(m.out_vld), 0);
    run(3);
    chk("err_held", 32'(resp_err), 1);
    rst = 1'b1;
    cyc();
    #1;
    chk("err_cleared", 32'(resp_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue_stage.md
FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 The block SHALL have parameter N_BITS, default 32, meaning PC/address width.
REQ-002 The block SHALL have parameter N_REDIR, default 4, meaning number of redirect sources; index 0 has highest priority.
REQ-003 The block SHALL have parameter FQ_DEPTH, default 4, meaning fetch-queue entries; power of two, >= 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning PC loaded on reset.
REQ-005 The block SHALL have port clk  in  1  clock, rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port redir_vld  in  N_REDIR  per-source redirect request.
REQ-008 The block SHALL have port redir_tgt  in  N_REDIR*N_BITS  per-source target; source i at bits [i*N_BITS +: N_BITS].
REQ-009 The block SHALL have port imem_req_vld  out  1  fetch request valid.
REQ-010 The block SHALL have port imem_req_addr  out  N_BITS  fetch address.
REQ-011 The block SHALL have port imem_req_rdy  in  1  memory accepts request.
REQ-012 The block SHALL have port imem_resp_vld  in  1  response valid; in request order, no backpressure.
REQ-013 The block SHALL have port imem_resp_data  in  32  instruction word.
REQ-014 The block SHALL have port out_vld  out  1  head instruction valid to decode.
REQ-015 The block SHALL have port out_pc  out  N_BITS  PC of head instruction.
REQ-016 The block SHALL have port out_instr  out  32  head instruction.
REQ-017 The block SHALL have port out_rdy  in  1  decode accepts (not stalled).
REQ-018 The block SHALL have port fq_count  out  $clog2(FQ_DEPTH)+1  allocated queue entries.
REQ-019 The block SHALL have port resp_err  out  1  sticky: response arrived with nothing outstanding.

Function
REQ-020 The block SHALL hold a fetch PC; imem_req_addr SHALL equal fetch PC combinationally.
REQ-021 The block SHALL define redir = OR of redir_vld and sel = lowest index i with redir_vld[i]=1.
REQ-022 imem_req_vld SHALL be 1 only when !rst, !redir, and (fq_count + drop_cnt) < FQ_DEPTH.
REQ-023 On request acceptance (imem_req_vld && imem_req_rdy), the block SHALL allocate the tail entry with fetch PC, mark it unfilled, and advance fetch PC by 4 modulo 2^N_BITS.
REQ-024 A response with drop_cnt > 0 SHALL be discarded and SHALL decrement drop_cnt; otherwise it SHALL fill the oldest unfilled entry.
REQ-025 out_vld SHALL be 1 when the head entry is allocated and filled, with out_pc/out_instr from that entry.
REQ-026 On out_vld && out_rdy && !redir, the head entry SHALL be freed in that cycle.
REQ-027 Allocate, fill and pop in the same cycle SHALL all take effect; fq_count changes by (alloc - pop).
REQ-028 On redir, fetch PC SHALL load the target of sel, all queue entries SHALL be freed, and pop SHALL be suppressed.
REQ-029 On redir, drop_cnt SHALL become (drop_cnt + unfilled allocated entries - imem_resp_vld); that cycle's response SHALL not be written.
REQ-030 Pointer wrap-around SHALL be modulo FQ_DEPTH; full is fq_count == FQ_DEPTH; empty is fq_count == 0.
REQ-031 A response when drop_cnt == 0 and no unfilled entry exists SHALL be ignored and SHALL set resp_err.
REQ-032 Fill-to-out_vld latency SHALL be one cycle; redirect-to-first-request latency SHALL be one cycle.

Reset
REQ-033 When rst is 1 at a clock edge, the block SHALL set fetch PC=RESET_PC, queue empty, drop_cnt=0, and resp_err=0.
REQ-034 During and after reset until a fill, the block SHALL drive out_vld=0, imem_req_vld=0 while rst=1, and fq_count=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries and outstanding drop state with no output in the following cycle.

Verification
REQ-036 Reset, rdy=1, response 1 cycle later, out_rdy=1 -> addresses 0x0,0x4,0x8...; out_pc sequence 0x0,0x4,0x8 in order.
REQ-037 out_rdy=0, memory always responding -> exactly 4 requests issued, fq_count=4, imem_req_vld=0 until a pop.
REQ-038 2 requests unfilled, redir_vld=4'b0110, tgt[1]=0x100 -> next addr 0x100; next 2 responses dropped; first out_pc=0x100.
REQ-039 Redirect in the same cycle as a response with 1 unfilled entry -> drop_cnt=0 afterwards, no stale output.
REQ-040 Fetch PC=0xFFFFFFFC accepted -> next request address 0x00000000.
REQ-041 imem_resp_vld with nothing outstanding -> resp_err=1 and held until rst; queue unchanged.
